// File: rtl/mips_instr_encoder.sv
// Field-level MIPS instruction encoder with an output FIFO and sequential word addressing.
// Optional branch delay-slot NOP insertion is enabled by defining MIPS_ENC_DELAY_SLOT_EN.
module mips_instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ADDR_W = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              illegal_op,
  output logic [7:0]        err_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

  logic [31:0]       mem_q [DEPTH];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              illegal_q;
  logic [7:0]        err_count_q;

  logic        full, empty, accept, push, pop;
  logic        slot_push, slot_block;
  logic [31:0] enc_word, push_word;

  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] sh, logic [5:0] funct);
    return {6'b000000, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Shifts drop rs, all other R-types drop shamt; fixed-zero fields are forced here.
  always_comb begin
    enc_word = '0;
    case (in_op[4:0])
      5'd0:    enc_word = '0;
      5'd1:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h20);
      5'd2:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h21);
      5'd3:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h22);
      5'd4:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h23);
      5'd5:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h24);
      5'd6:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h25);
      5'd7:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h26);
      5'd8:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h27);
      5'd9:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
      5'd10:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
      5'd11:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h00);
      5'd12:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h02);
      5'd13:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h03);
      5'd14:   enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
      5'd15:   enc_word = r_word(in_rs, 5'd0, in_rd, 5'd0, 6'h09);
      5'd16:   enc_word = r_word(5'd0, 5'd0, in_rd, 5'd0, 6'h10);
      5'd17:   enc_word = r_word(5'd0, 5'd0, in_rd, 5'd0, 6'h12);
      5'd18:   enc_word = i_word(6'b001000, in_rs, in_rt, in_imm);
      5'd19:   enc_word = i_word(6'b001001, in_rs, in_rt, in_imm);
      5'd20:   enc_word = i_word(6'b001100, in_rs, in_rt, in_imm);
      5'd21:   enc_word = i_word(6'b001101, in_rs, in_rt, in_imm);
      5'd22:   enc_word = i_word(6'b001111, 5'd0, in_rt, in_imm);
      5'd23:   enc_word = i_word(6'b100011, in_rs, in_rt, in_imm);
      5'd24:   enc_word = i_word(6'b101011, in_rs, in_rt, in_imm);
      5'd25:   enc_word = i_word(6'b100000, in_rs, in_rt, in_imm);
      5'd26:   enc_word = i_word(6'b000100, in_rs, in_rt, in_imm);
      5'd27:   enc_word = i_word(6'b000101, in_rs, in_rt, in_imm);
      5'd28:   enc_word = {6'b000010, in_target};
      5'd29:   enc_word = {6'b000011, in_target};
      5'd30:   enc_word = i_word(6'b000001, in_rs, 5'b10000, in_imm);
      5'd31:   enc_word = i_word(6'b000001, in_rs, 5'b10001, in_imm);
      default: enc_word = '0;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign in_ready  = reset && !full && !slot_block;
  assign accept    = in_valid && in_ready;
  assign push      = (accept && !in_op[5]) || slot_push;
  assign push_word = slot_push ? 32'h0000_0000 : enc_word;
  assign pop       = out_valid && out_ready;

`ifdef MIPS_ENC_DELAY_SLOT_EN
  typedef enum logic {StIdle, StSlot} state_e;
  state_e state_q, state_d;
  logic   is_ct;

  assign is_ct = !in_op[5] && ((in_op[4:0] == 5'd14) || (in_op[4:0] == 5'd15) ||
                               (in_op[4:0] >= 5'd26));

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // The NOP waits in SLOT until there is room, so it always lands right after the branch.
  always_comb begin
    state_d    = state_q;
    slot_push  = 1'b0;
    slot_block = 1'b0;
    case (state_q)
      StIdle: if (accept && is_ct) state_d = StSlot;
      StSlot: begin
        slot_block = 1'b1;
        if (!full) begin
          slot_push = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end
`else
  assign slot_push  = 1'b0;
  assign slot_block = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_addr_q  <= BASE_ADDR;
      illegal_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PtrOne;
        out_addr_q <= out_addr_q + ADDR_W'(1);
      end
      illegal_q <= accept && in_op[5];
      if (accept && in_op[5] && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign out_valid  = !empty;
  assign out_word   = mem_q[rd_ptr_q[PtrW-1:0]];
  assign out_addr   = out_addr_q;
  assign illegal_op = illegal_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed self-checking bench for mips_instr_encoder; a second instance with ADDR_W=2
// shares the stimulus to observe address wrap.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid, out_ready;
  logic [31:0] out_word;
  logic [8:0]  out_addr;
  logic        illegal_op;
  logic [7:0]  err_count;

  logic        w_in_ready, w_out_valid, w_illegal_op;
  logic [31:0] w_out_word;
  logic [1:0]  w_out_addr;
  logic [7:0]  w_err_count;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.DEPTH(4), .ADDR_W(9), .BASE_ADDR(9'd0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .illegal_op(illegal_op), .err_count(err_count)
  );

  mips_instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(2'd0)) dut_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_word(w_out_word), .out_addr(w_out_addr), .illegal_op(w_illegal_op),
    .err_count(w_err_count)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
    #0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    step(); step();
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (illegal_op !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal_op); else pass_cnt++;
    chk_cnt++; if (err_count !== 8'd0) $display("FAIL rst_err_count: got %0d want 0", err_count); else pass_cnt++;
    chk_cnt++; if (out_addr !== 9'd0) $display("FAIL rst_addr: got %0d want 0", out_addr); else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_add();
    do_reset();
    drive(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_word !== 32'h0022_1820) $display("FAIL add_word: got %h want 00221820", out_word); else pass_cnt++;
    chk_cnt++; if (out_addr !== 9'd0) $display("FAIL add_addr: got %0d want 0", out_addr); else pass_cnt++;
    step();
    chk_cnt++; if (out_word !== 32'h0022_1820) $display("FAIL add_stable: got %h want 00221820", out_word); else pass_cnt++;
    out_ready = 1'b1;
    step();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL add_drain: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_addr !== 9'd1) $display("FAIL add_addr_inc: got %0d want 1", out_addr); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    drive(6'd18, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    step();
    chk_cnt++; if (out_word !== 32'h2008_FFFF) $display("FAIL b2b_addi: got %h want 2008ffff", out_word); else pass_cnt++;
    chk_cnt++; if (out_addr !== 9'd0) $display("FAIL b2b_addr0: got %0d want 0", out_addr); else pass_cnt++;
    drive(6'd23, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0008, 26'h0);
    step();
    in_valid = 1'b0;
    chk_cnt++; if (out_word !== 32'h8FA9_0008) $display("FAIL b2b_lw: got %h want 8fa90008", out_word); else pass_cnt++;
    chk_cnt++; if (out_addr !== 9'd1) $display("FAIL b2b_addr1: got %0d want 1", out_addr); else pass_cnt++;
    step();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_full();
    logic [31:0] exp_w;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(6'd1, 5'd0, 5'd0, 5'(k + 1), 5'd0, 16'h0, 26'h0);
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL full_rdy%0d: got %b want 1", k, in_ready); else pass_cnt++;
      step();
    end
    drive(6'd1, 5'd0, 5'd0, 5'd5, 5'd0, 16'h0, 26'h0);
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_rdy_low: got %b want 0", in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (out_word !== 32'h0000_0820) $display("FAIL full_hold: got %h want 00000820", out_word); else pass_cnt++;
    out_ready = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_no_pass: got %b want 0", in_ready); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      exp_w = (32'(k + 1) << 11) | 32'h20;
      chk_cnt++; if (out_word !== exp_w) $display("FAIL full_word%0d: got %h want %h", k, out_word, exp_w); else pass_cnt++;
      chk_cnt++; if (out_addr !== 9'(k)) $display("FAIL full_addr%0d: got %0d want %0d", k, out_addr, k); else pass_cnt++;
      if (in_valid && in_ready) begin
        step();
        in_valid = 1'b0;
      end else begin
        step();
      end
    end
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL full_empty: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_shift_illegal();
    do_reset();
    drive(6'd11, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0);
    step();
    chk_cnt++; if (out_word !== 32'h0005_2080) $display("FAIL sll_word: got %h want 00052080", out_word); else pass_cnt++;
    out_ready = 1'b1;
    drive(6'd40, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL ill_ready: got %b want 1", in_ready); else pass_cnt++;
    step();
    in_valid = 1'b0;
    chk_cnt++; if (illegal_op !== 1'b1) $display("FAIL ill_pulse: got %b want 1", illegal_op); else pass_cnt++;
    chk_cnt++; if (err_count !== 8'd1) $display("FAIL ill_count: got %0d want 1", err_count); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ill_nopush: got %b want 0", out_valid); else pass_cnt++;
    step();
    chk_cnt++; if (illegal_op !== 1'b0) $display("FAIL ill_pulse_end: got %b want 0", illegal_op); else pass_cnt++;
    chk_cnt++; if (err_count !== 8'd1) $display("FAIL ill_count_hold: got %0d want 1", err_count); else pass_cnt++;
    chk_cnt++; if (out_addr !== 9'd1) $display("FAIL ill_addr: got %0d want 1", out_addr); else pass_cnt++;
  endtask

  task automatic test_encodings();
    vec_t v [9] = '{
      '{6'd14, 5'd31, 5'd3, 5'd4, 5'd5, 16'h0000, 26'h0, 32'h03E0_0008},
      '{6'd17, 5'd1, 5'd2, 5'd8, 5'd3, 16'h0000, 26'h0, 32'h0000_4012},
      '{6'd22, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3C01_1234},
      '{6'd27, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFE, 26'h0, 32'h1485_FFFE},
      '{6'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FF_FFFF, 32'h0BFF_FFFF},
      '{6'd30, 5'd2, 5'd7, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h0450_0010},
      '{6'd13, 5'd9, 5'd6, 5'd7, 5'd31, 16'h0000, 26'h0, 32'h0006_3FC3},
      '{6'd8, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0000, 26'h0, 32'h0022_1827},
      '{6'd24, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 26'h0, 32'hAFBF_0004}
    };
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(v[i].op, v[i].rs, v[i].rt, v[i].rd, v[i].sh, v[i].imm, v[i].tgt);
      step();
      in_valid = 1'b0;
      chk_cnt++; if (out_word !== v[i].exp) $display("FAIL enc_op%0d: got %h want %h", v[i].op, out_word, v[i].exp); else pass_cnt++;
`ifdef MIPS_ENC_DELAY_SLOT_EN
      if (is_ct(v[i].op)) begin
        step();
        chk_cnt++; if (out_word !== 32'h0 || out_valid !== 1'b1) $display("FAIL enc_slot_op%0d: got %h want 00000000", v[i].op, out_word); else pass_cnt++;
      end
`endif
      step();
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(6'd2, 5'd1, 5'd1, 5'(k), 5'd0, 16'h0, 26'h0);
      step();
      chk_cnt++; if (w_out_addr !== 2'(k)) $display("FAIL wrap_addr%0d: got %0d want %0d", k, w_out_addr, k % 4); else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    chk_cnt++; if (w_out_addr !== 2'd1) $display("FAIL wrap_final: got %0d want 1", w_out_addr); else pass_cnt++;
  endtask

  task automatic test_midstream_reset();
    do_reset();
    drive(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    step(); step();
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_pre: got %b want 1", out_valid); else pass_cnt++;
    reset = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_rdy: got %b want 0", in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_flush: got %b want 0", out_valid); else pass_cnt++;
    reset = 1'b1;
    #1;
  endtask

`ifdef MIPS_ENC_DELAY_SLOT_EN
  function automatic logic is_ct(input logic [5:0] op);
    return (op == 6'd14) || (op == 6'd15) || ((op >= 6'd26) && (op <= 6'd31));
  endfunction

  task automatic test_delay_slot();
    logic [31:0] exp_s [4] = '{32'h0C00_0100, 32'h0, 32'h0471_0004, 32'h0};
    do_reset();
    drive(6'd29, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100);
    step();
    drive(6'd31, 5'd3, 5'd0, 5'd0, 5'd0, 16'h0004, 26'h0);
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL ds_slot1: got %b want 0", in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL ds_idle1: got %b want 1", in_ready); else pass_cnt++;
    step();
    in_valid = 1'b0;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL ds_slot2: got %b want 0", in_ready); else pass_cnt++;
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (out_word !== exp_s[k] || out_addr !== 9'(k)) $display("FAIL ds_word%0d: got %h@%0d want %h@%0d", k, out_word, out_addr, exp_s[k], k); else pass_cnt++;
      step();
    end
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ds_empty: got %b want 0", out_valid); else pass_cnt++;
    do_reset();
    drive(6'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h4);
    step();
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL ds_rst_drop: got valid=%b rdy=%b want 0/1", out_valid, in_ready); else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_full();
    test_shift_illegal();
    test_encodings();
    test_addr_wrap();
    test_midstream_reset();
`ifdef MIPS_ENC_DELAY_SLOT_EN
    test_delay_slot();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
